// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared constants, state encoding and helpers for the 8-way round-robin arbiter
package arb_pkg;

    localparam int N_REQ            = 8;
    localparam int IDX_W            = 3;
    localparam int HOLD_MAX_DEFAULT = 15;
    localparam int CNT_W_DEFAULT    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Pointer arithmetic relies on the natural 3-bit wrap (7 + 1 -> 0).
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// rtl/rr_arbiter8_pick8.sv - combinational circular priority encoder, scans ptr, ptr+1, ... ptr+7 mod 8
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   offset;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign sel = ptr + offset;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter with held grants; ARB_HOLD_LIMIT_EN adds a hold limit
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             preempt
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] pick_sel;
    logic             pick_any;
    logic             owner_req;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .any (pick_any)
    );

    assign owner_req = req[grant_idx];

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             preempt_q;
    logic             preempt_nxt;
    logic             hold_at_limit;

    assign hold_at_limit = (hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
    logic [CNT_W-1:0] unused_hold_max;

    assign unused_hold_max = CNT_W'(HOLD_MAX);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= idx_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= hold_cnt_nxt;
            preempt_q <= preempt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_nxt = hold_cnt;
        preempt_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_sel;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
                // A voluntary release wins over the limit, so no preempt pulse in that case.
                if (!owner_req) begin
                    state_nxt = IDLE;
                    ptr_nxt   = idx_next(grant_idx);
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (hold_at_limit) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = idx_next(grant_idx);
                    preempt_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no combinational path from req.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (state == GRANT) begin
            grant       = idx_to_onehot(grant_idx);
            grant_valid = 1'b1;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 and rr_pick8 (ARB_HOLD_LIMIT_EN selects hold-limit checks)
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    logic [7:0] p_req;
    logic [2:0] p_ptr;
    logic [2:0] p_sel;
    logic       p_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    rr_pick8 u_pick (
        .req (p_req),
        .ptr (p_ptr),
        .sel (p_sel),
        .any (p_any)
    );

    typedef struct {
        logic [7:0] req;
        logic [2:0] ptr;
        logic [2:0] sel;
        logic       any;
    } pick_vec_t;

    pick_vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("valid_eq_or", 32'(grant_valid), 32'(|grant));
    endtask

    task automatic expect_grant(input string name, input logic [7:0] g, input logic [2:0] idx);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_valid"}, 32'(grant_valid), 32'(g != 8'h00));
        check({name, "_idx"}, 32'(grant_idx), 32'(idx));
    endtask

    initial begin
        vecs[0]  = '{8'h00, 3'd0, 3'd0, 1'b0};
        vecs[1]  = '{8'h01, 3'd0, 3'd0, 1'b1};
        vecs[2]  = '{8'h80, 3'd0, 3'd7, 1'b1};
        vecs[3]  = '{8'hFF, 3'd3, 3'd3, 1'b1};
        vecs[4]  = '{8'h21, 3'd6, 3'd0, 1'b1};
        vecs[5]  = '{8'h21, 3'd1, 3'd5, 1'b1};
        vecs[6]  = '{8'h88, 3'd4, 3'd7, 1'b1};
        vecs[7]  = '{8'h88, 3'd0, 3'd3, 1'b1};
        vecs[8]  = '{8'h01, 3'd7, 3'd0, 1'b1};
        vecs[9]  = '{8'h40, 3'd7, 3'd6, 1'b1};
        vecs[10] = '{8'h81, 3'd7, 3'd7, 1'b1};
        vecs[11] = '{8'h10, 3'd5, 3'd4, 1'b1};

        for (int i = 0; i < 12; i++) begin
            p_req = vecs[i].req;
            p_ptr = vecs[i].ptr;
            #1;
            check($sformatf("pick%0d_any", i), 32'(p_any), 32'(vecs[i].any));
            if (vecs[i].any) begin
                check($sformatf("pick%0d_sel", i), 32'(p_sel), 32'(vecs[i].sel));
            end
        end

        // Reset holds everything idle even with all requests high.
        reset = 1'b1;
        req   = 8'hFF;
        tick();
        tick();
        expect_grant("rst", 8'h00, 3'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        reset = 1'b0;
        tick();
        expect_grant("first", 8'h01, 3'd0);
        req = 8'h00;
        tick();
        expect_grant("first_rel", 8'h00, 3'd0);

        // Single requester 4; ptr must land on 5 so 3 beats 4 afterwards.
        req = 8'h10;
        tick();
        expect_grant("r4", 8'h10, 3'd4);
        tick();
        expect_grant("r4_hold", 8'h10, 3'd4);
        req = 8'h00;
        tick();
        expect_grant("r4_rel", 8'h00, 3'd4);
        req = 8'h18;
        tick();
        expect_grant("ptr5", 8'h08, 3'd3);
        req = 8'h00;
        tick();

        // Full rotation with wrap 7 -> 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(k);
            tick();
            expect_grant($sformatf("rot%0d", k), 8'h01 << e, e);
            tick();
            check($sformatf("rot%0d_hold", k), 32'(grant), 32'(8'h01 << e));
            req = 8'hFF & ~(8'h01 << e);
            tick();
            check($sformatf("rot%0d_gap", k), 32'(grant), 32'd0);
            req = 8'hFF;
        end

        // ptr=6 after owner 5: requester 0 beats 5, then 5 gets its turn.
        reset = 1'b1;
        req   = 8'h00;
        tick();
        reset = 1'b0;
        req   = 8'h20;
        tick();
        expect_grant("p5", 8'h20, 3'd5);
        req = 8'h00;
        tick();
        req = 8'h21;
        tick();
        expect_grant("p6_r0", 8'h01, 3'd0);
        req = 8'h20;
        tick();
        check("p6_gap", 32'(grant), 32'd0);
        tick();
        expect_grant("p6_r5", 8'h20, 3'd5);

        // Reset mid-grant clears ptr as well as the grant.
        req = 8'h00;
        tick();
        req = 8'h08;
        tick();
        expect_grant("mid3", 8'h08, 3'd3);
        reset = 1'b1;
        tick();
        expect_grant("mid_rst", 8'h00, 3'd0);
        reset = 1'b0;
        req   = 8'h88;
        tick();
        expect_grant("post_rst", 8'h08, 3'd3);

        // Owner 1 with requester 2 waiting.
        reset = 1'b1;
        req   = 8'h00;
        tick();
        reset = 1'b0;
        req   = 8'h06;
`ifdef ARB_HOLD_LIMIT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_grant($sformatf("lim%0d", c), 8'h02, 3'd1);
            check($sformatf("lim%0d_pre", c), 32'(preempt), 32'd0);
        end
        tick();
        check("lim_drop", 32'(grant), 32'd0);
        check("lim_pre", 32'(preempt), 32'd1);
        tick();
        expect_grant("lim_next", 8'h04, 3'd2);
        check("lim_pre_end", 32'(preempt), 32'd0);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            expect_grant($sformatf("nolim%0d", c), 8'h02, 3'd1);
            check($sformatf("nolim%0d_pre", c), 32'(preempt), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- The rotating 3-bit priority pointer steps 0..7 and wraps 7->0, the same way the team's mod-8 state counters do.
- Registered one-hot grant; each grant is held until the owner releases it.
- Sits between the requesting sub-blocks and the shared resource's select/enable input.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; the pointer is 3 bits.
- IDX_W, 3, width of the grant index and the priority pointer.
- HOLD_MAX, 15, maximum consecutive grant cycles per owner. Used only with ARB_HOLD_LIMIT_EN.
- CNT_W, 4, width of the hold counter. Must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  in  1  single system clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- req  in  8  level request, one bit per requester.
- grant  out  8  registered one-hot grant; all zero when nobody owns the resource.
- grant_idx  out  3  binary index of the current owner; holds its last value when grant_valid=0.
- grant_valid  out  1  high while some grant bit is set.
- preempt  out  1  one-cycle pulse when a grant is force-released (hold-limit feature only).

Behaviour:
- Reset (synchronous, active-high, evaluated at posedge clk):
  - state=IDLE, ptr=0, grant=0, grant_idx=0, grant_valid=0, preempt=0, hold_cnt=0.
  - Reset asserted mid-grant drops the grant at the next edge. Reset overrides all other inputs.
- States: IDLE and GRANT (2-bit encoding).
- IDLE:
  - grant=0.
  - If req!=0, select the first set bit scanning circularly from ptr: ptr, ptr+1, ... ptr+7, all mod 8.
  - At the next edge: state=GRANT, grant=onehot(sel), grant_idx=sel, grant_valid=1, hold_cnt=0.
  - Latency: req sampled high -> grant visible 1 cycle later.
  - If req==0, stay in IDLE; ptr is unchanged.
- GRANT:
  - While req[grant_idx]=1, grant holds. Requests from other requesters are ignored (no preemption by priority).
  - When req[grant_idx]=0 is sampled, at the next edge: grant=0, grant_valid=0, state=IDLE, ptr=grant_idx+1 mod 8 (7 wraps to 0).
  - Handover gap: at least 1 idle cycle between successive grants.
  - The owner must keep req high while it uses the resource. Dropping req is the release.
- Fairness:
  - The just-released requester becomes lowest priority.
  - With all 8 requesting continuously, grants rotate 0,1,...,7,0 with no requester skipped.
- Boundary cases:
  - A requester that drops req in the same cycle another raises it: arbitration uses the values sampled in IDLE.
  - If only the previous owner is requesting, it is re-granted after the 1-cycle gap.
  - req bits that pulse high only while another requester is granted are lost. Requesters must hold req until granted.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - preempt=0 whenever the hold-limit feature is compiled out.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - hold_cnt increments each cycle in GRANT.
  - When hold_cnt==HOLD_MAX-1 and req[grant_idx] is still 1, at the next edge: grant=0, state=IDLE, ptr=grant_idx+1, and preempt=1 for exactly that one cycle.
  - The owner's grant therefore lasts exactly HOLD_MAX cycles.
  - A normal release on the limit cycle takes precedence: no preempt pulse.
- Not defined:
  - No hold_cnt register; grants are unbounded.
  - preempt is tied to 0.

Decomposition:
- Package arb_pkg:
  - N_REQ, IDX_W constants.
  - State typedef IDLE=2'd0, GRANT=2'd1.
  - Default HOLD_MAX.
- Sub-module rr_pick8:
  - Purely combinational circular priority encoder.
  - Inputs req[7:0] and ptr[2:0]; outputs sel[2:0] and any.
  - Instantiated once in IDLE-path logic and unit-tested alone.

Test Plan:
1. reset=1 for 2 cycles with req=8'hFF -> grant=0, grant_valid=0, grant_idx=0. After release: grant=8'h01 one cycle after the first non-reset edge.
2. req=8'h10 alone -> grant=8'h10, grant_idx=4 one cycle later. Drop req[4] -> grant=0 the next cycle; ptr becomes 5.
3. req=8'hFF constant, each owner holding 2 cycles then dropping for 1 cycle -> grant_idx sequence 0,1,2,3,4,5,6,7,0, with a 1-cycle gap between grants; wrap 7->0 verified.
4. ptr=6 (after granting 5), req=8'h21 -> requester 0 is granted before 5. Then req=8'h20 -> requester 5 is granted.
5. Reset asserted while grant=8'h08 -> grant=0, state=IDLE, ptr=0 at the next edge. req=8'h88 afterwards -> requester 3 is granted.
6. With ARB_HOLD_LIMIT_EN, HOLD_MAX=4, req=8'h06 held -> requester 1 granted for exactly 4 cycles, preempt pulses 1 cycle, then requester 2 is granted. Without the macro, requester 1 is held indefinitely and preempt stays 0.
